// File: rtl/core_task_receiver_if.sv
// rtl/core_task_receiver_if.sv - task-dispatch and pipeline signal bundle for one core
//
// Purpose: groups the scheduler-facing and pipeline-facing signals of a
// core_task_receiver so that they travel as one port.
//   slave  : view used by core_task_receiver (the core endpoint)
//   master : view used by whoever drives it (scheduler plus pipeline)
// Signals:
//   Start, Insn_Data, Init_R0_Vect, Init_R0 : scheduler -> core
//   Ready                                   : core -> scheduler back-pressure
//   exec_start, exec_len, r0_value          : core -> pipeline task launch
//   exec_done, imem_rd_addr                 : pipeline -> core
//   imem_rd_data, proto_err                 : core -> pipeline / status
interface core_task_receiver_if #(
  parameter int NUM_CORES   = 16,
  parameter int FRAME_WIDTH = 128,
  parameter int REG_WIDTH   = 8,
  parameter int IMEM_DEPTH  = 16
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [NUM_CORES-1:0]           Start;
  logic [FRAME_WIDTH-1:0]         Insn_Data;
  logic [NUM_CORES-1:0]           Init_R0_Vect;
  logic [NUM_CORES*REG_WIDTH-1:0] Init_R0;
  logic                           Ready;
  logic                           exec_start;
  logic [AW:0]                    exec_len;
  logic [REG_WIDTH-1:0]           r0_value;
  logic                           exec_done;
  logic [AW-1:0]                  imem_rd_addr;
  logic [FRAME_WIDTH-1:0]         imem_rd_data;
  logic                           proto_err;

  modport slave (
    input  Start, Insn_Data, Init_R0_Vect, Init_R0, exec_done, imem_rd_addr,
    output Ready, exec_start, exec_len, r0_value, imem_rd_data, proto_err
  );

  modport master (
    output Start, Insn_Data, Init_R0_Vect, Init_R0, exec_done, imem_rd_addr,
    input  Ready, exec_start, exec_len, r0_value, imem_rd_data, proto_err
  );
endinterface

// File: rtl/core_task_receiver.sv
// rtl/core_task_receiver.sv - core-side task-dispatch endpoint with local frame buffer
//
// Purpose: captures this core's R0 value and a burst of instruction frames,
// launches the pipeline with a one-cycle exec_start pulse, and holds Ready
// low until the pipeline reports exec_done.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : core_task_receiver_if.slave (scheduler strobes, Ready, launch
//           outputs, pipeline completion, frame read port, proto_err)
module core_task_receiver #(
  parameter int CORE_ID     = 0,
  parameter int NUM_CORES   = 16,
  parameter int FRAME_WIDTH = 128,
  parameter int REG_WIDTH   = 8,
  parameter int IMEM_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  core_task_receiver_if.slave  bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(IMEM_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]             r_state;
  logic [AW:0]            r_wr_ptr;
  logic                   r_ready;
  logic                   r_exec_start;
  logic [AW:0]            r_exec_len;
  logic [REG_WIDTH-1:0]   r_r0;
  logic                   r_err;
  logic [FRAME_WIDTH-1:0] r_rd_data;
  logic [FRAME_WIDTH-1:0] r_mem [IMEM_DEPTH];

  wire w_start   = bus.Start[CORE_ID];
  wire w_r0_load = bus.Init_R0_Vect[CORE_ID];
  wire w_full    = (r_wr_ptr == DEPTH_L);

  // Frames land only in IDLE (slot 0) or LOAD below capacity; everything
  // else is either an overflow drop or a protocol violation.
  wire          w_wr_en   = w_start && ((r_state == S_IDLE) ||
                                        ((r_state == S_LOAD) && !w_full));
  wire [AW-1:0] w_wr_addr = (r_state == S_IDLE) ? '0 : r_wr_ptr[AW-1:0];

  // Other cores' vector bits and R0 slots are deliberately ignored.
  wire w_unused = ^{bus.Start, bus.Init_R0_Vect, bus.Init_R0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_ready      <= 1'b1;
      r_exec_start <= 1'b0;
      r_exec_len   <= '0;
      r_r0         <= '0;
      r_err        <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_exec_start <= 1'b0;
      r_rd_data    <= r_mem[bus.imem_rd_addr];
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= (AW+1)'(1);
          end
          if (bus.exec_done) r_err <= 1'b1;
        end
        S_LOAD: begin
          if (w_start) begin
            if (w_full) r_err <= 1'b1;
            else        r_wr_ptr <= r_wr_ptr + 1'b1;
          end else begin
            // Ready drops together with the launch pulse so the scheduler
            // sees back-pressure in the same cycle the pipeline starts.
            r_state      <= S_LAUNCH;
            r_ready      <= 1'b0;
            r_exec_start <= 1'b1;
            r_exec_len   <= r_wr_ptr;
          end
          if (bus.exec_done) r_err <= 1'b1;
        end
        S_LAUNCH: begin
          // exec_done here is a stale pulse, not a completion: no error.
          r_state <= S_RUN;
          if (w_start) r_err <= 1'b1;
        end
        default: begin
          if (w_start) r_err <= 1'b1;
          if (bus.exec_done) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_wr_ptr <= '0;
          end
        end
      endcase
      if (w_r0_load) r_r0 <= bus.Init_R0[CORE_ID*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Buffer contents survive reset; only the write pointer is cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= bus.Insn_Data;
  end

  assign bus.Ready        = r_ready;
  assign bus.exec_start   = r_exec_start;
  assign bus.exec_len     = r_exec_len;
  assign bus.r0_value     = r_r0;
  assign bus.imem_rd_data = r_rd_data;
  assign bus.proto_err    = r_err;
endmodule

// File: doc/core_task_receiver.md
Name: core_task_receiver

Overview:
- Core-side endpoint of the task-dispatch interface. One instance sits in each core, between the task scheduler outputs (Start, Insn_Data, Init_R0_Vect, Init_R0) and the core pipeline.
- Latches this core's initial R0 value and captures a burst of instruction frames into a local frame buffer.
- Launches the core pipeline, then holds Ready low until the pipeline reports completion.
- Ready is the back-pressure signal the scheduler uses to decide when to advance.

Parameters:
- CORE_ID, 0, index of this core in all per-core vectors.
- NUM_CORES, 16, width of the Start and Init_R0_Vect vectors.
- FRAME_WIDTH, 128, instruction frame width in bits; equals the task memory word width.
- REG_WIDTH, 8, width of each R0 slot in Init_R0.
- IMEM_DEPTH, 16, number of frames in the local buffer; must be a power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Start  in  NUM_CORES  per-core frame strobe from the scheduler; only bit CORE_ID is used
- Insn_Data  in  FRAME_WIDTH  instruction frame; valid in the cycle Start[CORE_ID]=1
- Init_R0_Vect  in  NUM_CORES  per-core R0 load request
- Init_R0  in  NUM_CORES*REG_WIDTH  packed R0 values; slot CORE_ID is bits [CORE_ID*REG_WIDTH +: REG_WIDTH]
- Ready  out  1  core idle and able to accept frames
- exec_start  out  1  one-cycle launch pulse to the pipeline
- exec_len  out  log2(IMEM_DEPTH)+1  number of frames captured for this task
- r0_value  out  REG_WIDTH  latched R0 for this task
- exec_done  in  1  pipeline finished the task (single-cycle pulse)
- imem_rd_addr  in  log2(IMEM_DEPTH)  pipeline frame fetch address
- imem_rd_data  out  FRAME_WIDTH  frame at imem_rd_addr, registered, 1-cycle latency
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Outputs: Ready=1, exec_start=0, exec_len=0, r0_value=0, proto_err=0, imem_rd_data=0.
  - Write pointer is cleared. Buffer contents are not reset.
- States:
  - IDLE:
    - Start[CORE_ID]=1 writes Insn_Data to buffer[0], sets wr_ptr=1, and moves to LOAD.
    - Ready stays 1.
  - LOAD:
    - Each cycle with Start[CORE_ID]=1 writes buffer[wr_ptr] and increments wr_ptr.
    - The first cycle with Start[CORE_ID]=0 moves to LAUNCH.
    - Ready stays 1 throughout LOAD, because the scheduler only advances frames while Ready is high.
  - LAUNCH (exactly one cycle):
    - exec_start=1 and exec_len=wr_ptr (held until the next LAUNCH).
    - Ready=0, registered on entry to LAUNCH.
    - Next state is RUN.
  - RUN:
    - Ready=0.
    - exec_done=1 moves to IDLE with Ready=1 on the following edge, and clears wr_ptr.
- Latency:
  - The last Start is at cycle N; Start is low at N+1.
  - The LAUNCH edge is at the end of N+1, so exec_start=1 and Ready=0 in cycle N+2.
- R0 capture:
  - In any state, Init_R0_Vect[CORE_ID]=1 loads r0_value from Init_R0 slot CORE_ID on the next edge.
  - r0_value is unaffected when the bit is 0.
- Overflow:
  - A Start in LOAD with wr_ptr=IMEM_DEPTH drops the frame; there is no wrap.
  - That Start sets proto_err. exec_len saturates at IMEM_DEPTH.
- Start[CORE_ID]=1 in LAUNCH or RUN: frame ignored, buffer unchanged, proto_err set.
- exec_done in IDLE or LOAD: ignored, proto_err set.
- exec_done in LAUNCH: ignored, no error; the pipeline must not finish before the launch.
- Read port:
  - imem_rd_data <= buffer[imem_rd_addr] every cycle.
  - Read and write of the same address in the same cycle returns the old data.
- proto_err is cleared only by reset.
- Reset mid-LOAD or mid-RUN: immediate return to the IDLE values above. Partially loaded frames are discarded logically (wr_ptr=0).

Test Plan:
- R0 load: reset, then Init_R0_Vect=1<<CORE_ID with slot CORE_ID=8'hA5 -> r0_value=8'hA5 next cycle. A vector bit for another core -> r0_value unchanged.
- Single task: 3 consecutive Start pulses with frames F0..F2 -> exec_start=1 exactly 2 cycles after the last Start, exec_len=3, Ready=0. Reading addresses 0..2 returns F0..F2 with 1-cycle latency.
- Completion: exec_done pulse in RUN -> Ready=1 next cycle. A new 1-frame burst -> exec_len=1, buffer[0] overwritten.
- Overflow (IMEM_DEPTH=16): 17 consecutive Start -> exec_len=16, buffer[15] holds frame 15 (frame 16 dropped), proto_err=1.
- Protocol errors: Start during RUN -> buffer unchanged, proto_err=1. exec_done in IDLE -> proto_err=1, state stays IDLE.
- Async reset: assert reset mid-burst (after 2 of 5 frames) with no clock edge -> Ready=1 and exec_start=0 immediately. After release, a fresh 1-frame burst -> exec_len=1.
